// File: rtl/exec_muldiv_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
package exec_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    // Radix-2 divider iterations for 32-bit operands.
    localparam int unsigned DIV_CYCLES = 32;

endpackage

// File: rtl/exec_muldiv_if.sv
// Execute-stage <-> mul/div unit signal bundle.
interface exec_muldiv_if;
    import exec_muldiv_pkg::*;

    logic       valid_i;
    muldiv_op_t op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic       advance_i;
    logic       flush_i;
    logic       stall_o;
    logic       done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // Execute-stage / pipeline-control side.
    modport master (
        output valid_i, op_i, a_i, b_i, advance_i, flush_i,
        input  stall_o, done_o, hi_o, lo_o
    );

    // Mul/div unit side.
    modport slave (
        input  valid_i, op_i, a_i, b_i, advance_i, flush_i,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/exec_muldiv_div_radix2.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle.
// done_o, quot_o and rem_o present the result of the final iteration
// combinationally so the caller can register it on the same edge.
module div_radix2
    import exec_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);
    localparam logic [4:0] LAST = 5'(DIV_CYCLES - 1);

    logic [31:0] rem_q, quot_q, dvsr_q;
    logic [4:0]  count_q;
    logic        busy_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_d, quot_d;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // No borrow out of bit 32 exactly when the partial remainder >= divisor.
    always_comb begin
        shifted = {rem_q, quot_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        rem_d   = diff[32] ? shifted[31:0] : diff[31:0];
        quot_d  = {quot_q[30:0], ~diff[32]};
    end

    // Iteration state: load on start, step while busy, drop busy after last step.
    always_ff @(posedge clk) begin
        if (reset || kill_i) begin
            busy_q  <= 1'b0;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= dividend_i;
            dvsr_q  <= divisor_i;
        end else if (busy_q) begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            count_q <= count_q + 5'd1;
            if (count_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (count_q == LAST);
    assign quot_o = quot_d;
    assign rem_o  = rem_d;
endmodule

// File: rtl/exec_muldiv.sv
// Execute-stage multiply/divide unit producing {HI, LO} for MULT/MULTU/DIV/DIVU.
module exec_muldiv
    import exec_muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    exec_muldiv_if.slave io
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e      state_q;
    muldiv_op_t  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        is_div_in, a_neg_in, b_neg_in, div_start;
    logic [31:0] a_mag_in, b_mag_in;
    logic [63:0] mul_a, mul_b, product;
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;
    logic [31:0] div_hi, div_lo;

    // Operand magnitudes for the unsigned core, taken from the live inputs on accept.
    always_comb begin
        is_div_in = (io.op_i == OP_DIV) || (io.op_i == OP_DIVU);
        a_neg_in  = (io.op_i == OP_DIV) && io.a_i[31];
        b_neg_in  = (io.op_i == OP_DIV) && io.b_i[31];
        a_mag_in  = a_neg_in ? -io.a_i : io.a_i;
        b_mag_in  = b_neg_in ? -io.b_i : io.b_i;
        div_start = (state_q == S_IDLE) && io.valid_i && !io.flush_i && is_div_in;
    end

    div_radix2 u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .kill_i     (io.flush_i),
        .dividend_i (a_mag_in),
        .divisor_i  (b_mag_in),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // 64-bit product on latched operands; sign extension selects MULT vs MULTU.
    always_comb begin
        mul_a   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
        mul_b   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
        product = mul_a * mul_b;
    end

    // Sign fix-up of the unsigned core result; divide-by-zero returns all-ones / raw a.
    always_comb begin
        div_lo = div_quot;
        div_hi = div_rem;
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else if (op_q == OP_DIV) begin
            if (a_q[31] ^ b_q[31]) div_lo = -div_quot;
            if (a_q[31])           div_hi = -div_rem;
        end
    end

    // Control FSM with registered result and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (io.flush_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.valid_i) begin
                        op_q    <= io.op_i;
                        a_q     <= io.a_i;
                        b_q     <= io.b_i;
                        state_q <= is_div_in ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    hi_q    <= product[63:32];
                    lo_q    <= product[31:0];
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DIV: begin
                    if (div_done) begin
                        hi_q    <= div_hi;
                        lo_q    <= div_lo;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (!div_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (io.advance_i) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io.stall_o = io.valid_i && (state_q != S_DONE) && !io.flush_i;
    assign io.done_o  = done_q;
    assign io.hi_o    = hi_q;
    assign io.lo_o    = lo_q;
endmodule
